mantissa_aligner: RTL

MANTISSA_ALIGNER -- requirements
Module: mantissa_aligner

---
 rtl/fpu_pkg.sv | 13 +
 rtl/align_step.sv | 24 ++
 rtl/mantissa_aligner.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: aligner state encoding and guard/round width.
package fpu_pkg;

  // Guard and round bits appended below the mantissa LSB before shifting.
  localparam int unsigned GRS_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } align_state_e;

endpackage

// File: rtl/align_step.sv
// One bounded right shift: returns the shifted value and whether any set
// bit fell off the bottom.
//   i_value      value to shift
//   i_amt        shift amount (caller keeps it <= W)
//   o_value_c    i_value >> i_amt
//   o_sticky_c   OR of the i_amt bits shifted out
module align_step #(
  parameter int unsigned W     = 26,
  parameter int unsigned AMT_W = 5
) (
  input  logic [W-1:0]     i_value,
  input  logic [AMT_W-1:0] i_amt,
  output logic [W-1:0]     o_value_c,
  output logic             o_sticky_c
);

  logic [W-1:0] w_keep_mask;

  assign o_value_c   = i_value >> i_amt;
  // Ones over the bits that survive; its complement selects the lost bits.
  assign w_keep_mask = {W{1'b1}} << i_amt;
  assign o_sticky_c  = |(i_value & ~w_keep_mask);

endmodule

// File: rtl/mantissa_aligner.sv
// Aligns two mantissas for FP add/sub: routes the larger-exponent mantissa
// through unshifted and right-shifts the other one by the exponent
// difference, keeping guard/round bits and a sticky bit.
// The default build shifts at most STEP bits per cycle. Defining
// ALIGNER_FAST_EN replaces this with a single full-width barrel shift.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   in_valid/in_ready     operand handshake (ready only in IDLE)
//   exp_diff, exp_uf      a_exp - b_exp mod 2^EXP_W, and borrow flag
//   mant_a, mant_b        operand mantissas (hidden bit included)
//   out_valid/out_ready   result handshake
//   mant_big              unshifted larger-exponent mantissa
//   mant_small            shifted mantissa with guard and round bits
//   sticky                OR of all bits shifted below mant_small
//   swapped               operands were exchanged
module mantissa_aligner
  import fpu_pkg::*;
#(
  parameter int unsigned EXP_W  = 8,
  parameter int unsigned MANT_W = 24,
  parameter int unsigned STEP   = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [EXP_W-1:0]        exp_diff,
  input  logic                    exp_uf,
  input  logic [MANT_W-1:0]       mant_a,
  input  logic [MANT_W-1:0]       mant_b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [MANT_W-1:0]       mant_big,
  output logic [MANT_W+GRS_W-1:0] mant_small,
  output logic                    sticky,
  output logic                    swapped
);

  localparam int unsigned SM_W    = MANT_W + GRS_W;
  localparam int unsigned SAT_AMT = SM_W;
  localparam int unsigned REM_W   = $clog2(SAT_AMT + 1);

  align_state_e      r_state;
  logic              r_in_ready;
  logic              r_out_valid;
  logic [MANT_W-1:0] r_big;
  logic [SM_W-1:0]   r_small;
  logic              r_sticky;
  logic              r_swapped;
  logic [REM_W-1:0]  r_rem;

  logic [EXP_W:0]    w_amt_uf;
  logic [EXP_W:0]    w_amt_raw;
  logic [REM_W-1:0]  w_amt_sat;
  logic [MANT_W-1:0] w_big_in;
  logic [SM_W-1:0]   w_small_in;
  logic [REM_W-1:0]  w_step;
  logic [SM_W-1:0]   w_shifted;
  logic              w_lost;

  // Operand routing: on borrow the true difference is 2^EXP_W - exp_diff.
  assign w_amt_uf   = {1'b1, {EXP_W{1'b0}}} - {1'b0, exp_diff};
  assign w_amt_raw  = exp_uf ? w_amt_uf : {1'b0, exp_diff};
  assign w_big_in   = exp_uf ? mant_b : mant_a;
  assign w_small_in = exp_uf ? {mant_a, {GRS_W{1'b0}}} : {mant_b, {GRS_W{1'b0}}};

  // Beyond SM_W every bit lands in sticky, so clamp there.
  always_comb begin
    w_amt_sat = REM_W'(SAT_AMT);
    if (32'(w_amt_raw) < SAT_AMT) begin
      w_amt_sat = REM_W'(w_amt_raw);
    end
  end

  // Per-cycle shift amount.
`ifdef ALIGNER_FAST_EN
  assign w_step = r_rem;
`else
  always_comb begin
    w_step = r_rem;
    if (32'(r_rem) > STEP) begin
      w_step = REM_W'(STEP);
    end
  end
`endif

  align_step #(
    .W     (SM_W),
    .AMT_W (REM_W)
  ) u_align_step (
    .i_value    (r_small),
    .i_amt      (w_step),
    .o_value_c  (w_shifted),
    .o_sticky_c (w_lost)
  );

  // Control FSM and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_big       <= '0;
      r_small     <= '0;
      r_sticky    <= 1'b0;
      r_swapped   <= 1'b0;
      r_rem       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_big      <= w_big_in;
            r_small    <= w_small_in;
            r_sticky   <= 1'b0;
            r_swapped  <= exp_uf;
            r_rem      <= w_amt_sat;
            r_in_ready <= 1'b0;
            if (w_amt_sat == '0) begin
              r_state     <= DONE;
              r_out_valid <= 1'b1;
            end else begin
              r_state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          r_small  <= w_shifted;
          r_sticky <= r_sticky | w_lost;
          r_rem    <= r_rem - w_step;
          if (r_rem == w_step) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
          end
        end
        DONE: begin
          // Results hold until consumed; in_ready rises only afterwards.
          if (out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign mant_big   = r_big;
  assign mant_small = r_small;
  assign sticky     = r_sticky;
  assign swapped    = r_swapped;

endmodule
